regfile_2r1w: RTL

Parametrised register file with one write port and two synchronous read ports. It is built around a generic ADDR_W-to-2^ADDR_W one-hot write-select decoder, which replaces the fixed 5-to-32 gate-level decoder. It adds registered reads, write-to-read forwarding, an optional hardwired zero register and a registered one-hot write-select debug output. It sits in the datapath between instruction decode (register addresses) and the ALU operand latches.

---
 rtl/regfile_2r1w.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// Register file: one write port, two registered read ports, write-to-read forwarding, optional zero register.
// Write and read latency are 1 cycle. There is no backpressure, so each port accepts one read per cycle.
module regfile_2r1w #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en_a,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic                     rd_valid_a,
  input  logic                     rd_en_b,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic                     rd_valid_b,
  output logic [(1<<ADDR_W)-1:0]   wr_sel_q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  wsel_q;
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_b_q;

  // One-hot write decode. Register 0 is never selected when it is hardwired to zero.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) wr_sel[i] = 1'b1;
    end
    if (ZERO_REG != 0) wr_sel[0] = 1'b0;
  end

  // The read value checks the zero register first, then the forwarded write, then storage.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    if (rd_en_a) begin
      if ((ZERO_REG != 0) && (rd_addr_a == '0)) rd_data_a_d = '0;
      else if (wr_sel[rd_addr_a])               rd_data_a_d = wr_data;
      else                                      rd_data_a_d = regs_q[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b_d = rd_data_b_q;
    if (rd_en_b) begin
      if ((ZERO_REG != 0) && (rd_addr_b == '0)) rd_data_b_d = '0;
      else if (wr_sel[rd_addr_b])               rd_data_b_d = wr_data;
      else                                      rd_data_b_d = regs_q[rd_addr_b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      wsel_q       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) regs_q[i] <= wr_data;
      end
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_en_a;
      rd_valid_b_q <= rd_en_b;
      wsel_q       <= wr_sel;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign wr_sel_q   = wsel_q;

endmodule
